// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns and BCD nibble width shared by the 7-segment scanner
package seg7_pkg;

  localparam int NIBBLE_W = 4;

  // bit0 = segment a ... bit6 = segment g, active-high
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - maps one BCD nibble to an active-high segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [6:0]          pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// rtl/bcd_seg7_scan.sv - multiplexed 7-segment driver with frame-aligned commit of BCD values
module bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int PRESCALE       = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLANK_LZ       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NIBBLE_W*DIGITS-1:0] bcd_in,
  input  logic                       bcd_valid,
  output logic                       bcd_ready,
  output logic [6:0]                 seg,
  output logic [DIGITS-1:0]          dig_en,
  output logic                       frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [6:0]    SEG_RESET = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  logic [NIBBLE_W*DIGITS-1:0] shadow;
  logic [NIBBLE_W*DIGITS-1:0] disp;
  logic                       pending;
  logic [PW-1:0]              presc;
  logic [IW-1:0]              idx;

  logic                       boundary;
  logic [NIBBLE_W-1:0]        cur_nibble;
  logic                       cur_blank;
  logic                       run_zero;
  logic [6:0]                 dec_pattern;
  logic [6:0]                 seg_next;
  logic [DIGITS-1:0]          dig_en_next;

  assign bcd_ready = !pending;
  assign boundary  = (presc == PRE_LAST) && (idx == IDX_LAST);

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    cur_nibble  = '0;
    cur_blank   = 1'b0;
    run_zero    = 1'b1;
    dig_en_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (disp[i*NIBBLE_W +: NIBBLE_W] == '0);
      if (idx == IW'(i)) begin
        cur_nibble     = disp[i*NIBBLE_W +: NIBBLE_W];
        cur_blank      = (BLANK_LZ != 0) && (i > 0) && run_zero;
        dig_en_next[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .nibble  (cur_nibble),
    .pattern (dec_pattern)
  );

  always_comb begin
    seg_next = cur_blank ? SEG_OFF : dec_pattern;
    if (SEG_ACTIVE_LOW != 0) begin
      seg_next = ~seg_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      presc      <= '0;
      idx        <= '0;
      dig_en     <= '0;
      seg        <= SEG_RESET;
      frame_tick <= 1'b0;
    end else begin
      if (presc == PRE_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // Commit and accept are exclusive: a transfer needs pending clear.
      if (boundary && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end else if (bcd_valid && !pending) begin
        shadow  <= bcd_in;
        pending <= 1'b1;
      end

      frame_tick <= boundary;
      dig_en     <= dig_en_next;
      seg        <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb/tb_bcd_seg7_scan.sv - directed self-checking bench for bcd_seg7_scan
module tb_bcd_seg7_scan;

  localparam int DIGITS   = 3;
  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;

  logic       ready, frame_tick;
  logic [6:0] seg;
  logic [2:0] dig_en;

  logic       nlz_ready, nlz_tick;
  logic [6:0] nlz_seg;
  logic [2:0] nlz_dig_en;

  logic       al_ready, al_tick;
  logic [6:0] al_seg;
  logic [2:0] al_dig_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seg7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SEG_ACTIVE_LOW(0), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(ready),
    .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  bcd_seg7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SEG_ACTIVE_LOW(0), .BLANK_LZ(0)) u_nlz (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(nlz_ready),
    .seg(nlz_seg), .dig_en(nlz_dig_en), .frame_tick(nlz_tick)
  );

  bcd_seg7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) u_al (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(al_ready),
    .seg(al_seg), .dig_en(al_dig_en), .frame_tick(al_tick)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic dig(input string tag, input logic [2:0] en, input logic [6:0] s, input logic [6:0] n);
    logic [6:0] inv;
    inv = ~s;
    chk({tag, "_dig_en"}, dig_en, en);
    chk({tag, "_seg"}, seg, s);
    chk({tag, "_al_seg"}, al_seg, inv);
    chk({tag, "_al_dig_en"}, al_dig_en, en);
    chk({tag, "_nlz_seg"}, nlz_seg, n);
  endtask

  // Starts at the negedge of a frame_tick cycle; ends at the next one.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] n0, input logic [6:0] n1,
                             input logic [6:0] n2);
    step(); dig({tag, "_d0a"}, 3'b001, s0, n0);
    repeat (3) step(); dig({tag, "_d0b"}, 3'b001, s0, n0);
    step(); dig({tag, "_d1a"}, 3'b010, s1, n1);
    repeat (3) step(); dig({tag, "_d1b"}, 3'b010, s1, n1);
    step(); dig({tag, "_d2a"}, 3'b100, s2, n2);
    chk({tag, "_tick_low"}, frame_tick, 1'b0);
    repeat (3) step(); dig({tag, "_d2b"}, 3'b100, s2, n2);
    chk({tag, "_next_tick"}, frame_tick, 1'b1);
  endtask

  task automatic send(input string tag, input logic [11:0] v);
    int n;
    n = 0;
    while (!ready && n < 100) begin step(); n++; end
    chk({tag, "_ready_before"}, ready, 1'b1);
    bcd_in = v;
    bcd_valid = 1'b1;
    @(posedge clk);
    #1 bcd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_drop"}, ready, 1'b0);
  endtask

  task automatic wait_commit(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin step(); n++; end
    chk({tag, "_commit_ready"}, ready, 1'b1);
    chk({tag, "_commit_tick"}, frame_tick, 1'b1);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (!frame_tick && n < 100) begin step(); n++; end
    chk({tag, "_tick_seen"}, frame_tick, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_seg"}, seg, 7'h00);
    chk({tag, "_al_seg"}, al_seg, 7'h7F);
    chk({tag, "_dig_en"}, dig_en, 3'b000);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  initial begin
    // Reset state, then scan of the zero display.
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;
    step(); dig("r1", 3'b001, 7'h3F, 7'h3F);
    repeat (3) step(); dig("r4", 3'b001, 7'h3F, 7'h3F);
    step(); dig("r5", 3'b010, 7'h00, 7'h3F);
    chk("r5_tick", frame_tick, 1'b0);

    // 0x123 appears after the next frame boundary and repeats.
    send("s123", 12'h123);
    wait_commit("s123");
    check_frame("f123a", 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);
    check_frame("f123b", 7'h4F, 7'h5B, 7'h06, 7'h4F, 7'h5B, 7'h06);

    // Leading-zero blanking.
    send("s007", 12'h007);
    wait_commit("s007");
    check_frame("f007", 7'h07, 7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F);
    send("s000", 12'h000);
    wait_commit("s000");
    check_frame("f000", 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F);

    // Dash nibble counts as non-zero.
    send("s1a5", 12'h1A5);
    wait_commit("s1a5");
    check_frame("f1a5", 7'h6D, 7'h40, 7'h06, 7'h6D, 7'h40, 7'h06);

    // Back-to-back: 0x222 held valid is accepted only after 0x111 commits.
    send("s111", 12'h111);
    bcd_in = 12'h222;
    bcd_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!ready && n < 100) begin step(); n++; end
    end
    chk("b2b_commit_ready", ready, 1'b1);
    chk("b2b_commit_tick", frame_tick, 1'b1);
    @(posedge clk);
    #1 bcd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_222_taken", ready, 1'b0);
    dig("f111_d0a", 3'b001, 7'h06, 7'h06);
    repeat (3) step(); dig("f111_d0b", 3'b001, 7'h06, 7'h06);
    step(); dig("f111_d1a", 3'b010, 7'h06, 7'h06);
    repeat (3) step(); dig("f111_d1b", 3'b010, 7'h06, 7'h06);
    step(); dig("f111_d2a", 3'b100, 7'h06, 7'h06);
    repeat (3) step(); dig("f111_d2b", 3'b100, 7'h06, 7'h06);
    chk("f222_commit_tick", frame_tick, 1'b1);
    chk("f222_commit_ready", ready, 1'b1);
    check_frame("f222", 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B);

    // Reset mid-frame with a pending value discards it.
    send("s456", 12'h456);
    repeat (2) step();
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    wait_tick("post_rst");
    chk("post_rst_ready", ready, 1'b1);
    check_frame("fpost", 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
